// File: rtl/alu_rr_arbiter_if.sv
// alu_rr_arbiter_if: request, ALU and response bundle of alu_rr_arbiter; req_lock exists only with ALU_ARB_LOCK_EN
interface alu_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [8*N_REQ-1:0] req_a;
  logic [8*N_REQ-1:0] req_b;
  logic [4*N_REQ-1:0] req_op;
  logic [4*N_REQ-1:0] req_mode;
`ifdef ALU_ARB_LOCK_EN
  logic [N_REQ-1:0] req_lock;
`endif
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_opcode;
  logic alu_m;
  logic alu_cn;
  logic alu_l;
  logic alu_h;
  logic [7:0] alu_r;
  logic rsp_valid;
  logic rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic [ID_W-1:0] rsp_id;
  modport slave (
    input req_valid, req_a, req_b, req_op, req_mode, alu_r, rsp_ready,
`ifdef ALU_ARB_LOCK_EN
    input req_lock,
`endif
    output req_ready, alu_a, alu_b, alu_opcode, alu_m, alu_cn, alu_l, alu_h,
    output rsp_valid, rsp_data, rsp_flags, rsp_id
  );
  modport master (
    output req_valid, req_a, req_b, req_op, req_mode, alu_r, rsp_ready,
`ifdef ALU_ARB_LOCK_EN
    output req_lock,
`endif
    input req_ready, alu_a, alu_b, alu_opcode, alu_m, alu_cn, alu_l, alu_h,
    input rsp_valid, rsp_data, rsp_flags, rsp_id
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one 8-bit 74181-style ALU with tagged responses; ALU_ARB_LOCK_EN adds req_lock
module alu_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  alu_rr_arbiter_if.slave bus,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] owner;
  logic any;
  logic legal;
`ifdef ALU_ARB_LOCK_EN
  logic locked;
  logic [ID_W-1:0] lock_id;
`endif
  // descending scan so the requester closest after rr_ptr overrides the rest
  always_comb begin
    gnt = rr_ptr;
    any = 1'b0;
    for (int k = N_REQ; k >= 1; k--)
      if (bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        gnt = ID_W'((int'(rr_ptr) + k) % N_REQ);
        any = 1'b1;
      end
`ifdef ALU_ARB_LOCK_EN
    if (locked && bus.req_valid[lock_id]) gnt = lock_id;
`endif
  end
  assign legal = (bus.alu_m & bus.alu_l) | (~bus.alu_m & ~bus.alu_cn & bus.alu_l)
               | (bus.alu_m & bus.alu_h) | (~bus.alu_m & bus.alu_cn & bus.alu_h);
  assign bus.req_ready = (state == IDLE && rst_n && any) ? (N_REQ'(1) << gnt) : '0;
  assign busy = (state != IDLE);
  // the alu_* registers double as operand registers; they are cleared on leaving EXEC
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= ID_W'(N_REQ - 1);
      owner <= '0;
      {bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_m, bus.alu_cn, bus.alu_l, bus.alu_h} <= '0;
      {bus.rsp_valid, bus.rsp_data, bus.rsp_flags, bus.rsp_id} <= '0;
`ifdef ALU_ARB_LOCK_EN
      locked <= 1'b0;
      lock_id <= '0;
`endif
    end else
      case (state)
        IDLE: begin
`ifdef ALU_ARB_LOCK_EN
          locked <= any & bus.req_lock[gnt];
          lock_id <= gnt;
`endif
          if (any) begin
            state <= EXEC;
            rr_ptr <= gnt;
            owner <= gnt;
            bus.alu_a <= bus.req_a[8*int'(gnt) +: 8];
            bus.alu_b <= bus.req_b[8*int'(gnt) +: 8];
            bus.alu_opcode <= bus.req_op[4*int'(gnt) +: 4];
            {bus.alu_m, bus.alu_cn, bus.alu_l, bus.alu_h} <= bus.req_mode[4*int'(gnt) +: 4];
          end
        end
        EXEC: begin
          state <= RESP;
          {bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_m, bus.alu_cn, bus.alu_l, bus.alu_h} <= '0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data <= legal ? bus.alu_r : 8'h00;
          bus.rsp_flags <= legal ? {1'b0, ~^bus.alu_r, bus.alu_r[7], bus.alu_r == 8'h00} : 4'b1000;
          bus.rsp_id <= owner;
        end
        RESP: if (bus.rsp_ready) begin
          state <= IDLE;
          bus.rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: randomized self-checking bench for alu_rr_arbiter with a behavioural ALU and arbitration model
module tb_alu_rr_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int checks = 0;
  int errors = 0;
  int model_last = N - 1;
  alu_rr_arbiter_if #(.N_REQ(N), .ID_W(2)) bus();
  alu_rr_arbiter #(.N_REQ(N), .ID_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy));
  always #5 clk = ~clk;
  logic [52:0] outs;
  assign outs = {bus.req_ready, bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_m, bus.alu_cn, bus.alu_l,
                 bus.alu_h, bus.rsp_valid, bus.rsp_data, bus.rsp_flags, bus.rsp_id, busy};
  // stand-in ALU: every alu_* input bit influences the result
  function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] op, logic [3:0] mode);
    if (mode[3]) return (op == 4'b1100) ? 8'h00 : a ^ b ^ {op, op} ^ {2'b00, mode[1:0], 4'b0000};
    return a + b + {4'b0000, op ^ 4'b1001} + {7'd0, mode[2]} + {3'd0, mode[0], 1'b0, ~mode[1], 2'b00};
  endfunction
  function automatic logic [11:0] ref_rsp(logic [7:0] a, logic [7:0] b, logic [3:0] op, logic [3:0] mode);
    logic [7:0] r;
    logic legal;
    legal = mode[3] ? |mode[1:0] : (mode[2] ? mode[0] : mode[1]);
    r = alu_fn(a, b, op, mode);
    if (!legal) return {8'h00, 4'b1000};
    return {r, 1'b0, ($countones(r) % 2 == 0), r[7], r == 8'h00};
  endfunction
  assign bus.alu_r = alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode, {bus.alu_m, bus.alu_cn, bus.alu_l, bus.alu_h});
  function automatic int rr_pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  function automatic int onehot_idx(logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v == (N'(1) << k)) return k;
    return -1;
  endfunction
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [3:0] mode);
    bus.req_a[8*i +: 8] = a;
    bus.req_b[8*i +: 8] = b;
    bus.req_op[4*i +: 4] = op;
    bus.req_mode[4*i +: 4] = mode;
  endtask
  task automatic rand_all();
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
  endtask
  task automatic drain(output bit ok);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 10 && (busy || bus.rsp_valid); n++) step();
    ok = !busy && !bus.rsp_valid;
  endtask
  // single-requester transaction; returns what the DUT did, judged by the caller
  task automatic txn(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                     input logic [3:0] mode, output int g, output int lat, output logic [11:0] rsp,
                     output int id, output logic [27:0] snap, output bit idle_ok);
    g = -1; lat = -1; rsp = '0; id = -1; snap = '0; idle_ok = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(i, a, b, op, mode);
    bus.req_valid = N'(1) << i;
    #1;
    for (int n = 0; n < 10 && bus.req_ready == '0; n++) step();
    g = onehot_idx(bus.req_ready);
    step();
    bus.req_valid = '0;
    set_req(i, ~a, ~b, ~op, ~mode);
    snap = {bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_m, bus.alu_cn, bus.alu_l, bus.alu_h};
    for (int n = 1; n < 8 && lat < 0; n++) if (bus.rsp_valid) lat = n; else step();
    rsp = {bus.rsp_data, bus.rsp_flags};
    id = int'(bus.rsp_id);
    step();
    idle_ok = !busy && !bus.rsp_valid && bus.req_ready == '0 &&
              {bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_m, bus.alu_cn, bus.alu_l, bus.alu_h} == '0;
  endtask
  task automatic test_reset();
    step();
    step();
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
    rst_n = 1'b1;
    bus.req_valid = '0;
    model_last = N - 1;
  endtask
  task automatic test_directed();
    int g, lat, id;
    logic [11:0] rsp;
    logic [27:0] snap;
    bit ok;
    logic [39:0] tbl [3];
    tbl[0] = {4'd0, 8'h05, 8'h03, 4'b1001, 4'b0010, 12'h080};
    tbl[1] = {4'd0, 8'h37, 8'h9C, 4'b1100, 4'b1010, 12'h005};
    tbl[2] = {4'd2, 8'h5A, 8'hC3, 4'b0110, 4'b0000, 12'h008};
    for (int k = 0; k < 3; k++) begin
      txn(int'(tbl[k][39:36]), tbl[k][35:28], tbl[k][27:20], tbl[k][19:16], tbl[k][15:12], g, lat, rsp, id, snap, ok);
      checks += 6;
      if (g != int'(tbl[k][39:36])) begin errors++; $display("FAIL dir_grant[%0d] got %0d exp %0d", k, g, tbl[k][39:36]); end
      if (lat != 2) begin errors++; $display("FAIL dir_latency[%0d] got %0d exp 2", k, lat); end
      if (rsp !== tbl[k][11:0]) begin errors++; $display("FAIL dir_rsp[%0d] got %h exp %h", k, rsp, tbl[k][11:0]); end
      if (id != int'(tbl[k][39:36])) begin errors++; $display("FAIL dir_id[%0d] got %0d exp %0d", k, id, tbl[k][39:36]); end
      if (snap !== tbl[k][35:12]) begin errors++; $display("FAIL dir_alu_drive[%0d] got %h exp %h", k, snap, tbl[k][35:12]); end
      if (!ok) begin errors++; $display("FAIL dir_idle[%0d] got outputs %h exp quiet", k, outs); end
      model_last = int'(tbl[k][39:36]);
    end
  endtask
  task automatic test_random();
    int g, lat, id, i;
    logic [7:0] a, b;
    logic [3:0] op, mode;
    logic [11:0] rsp;
    logic [27:0] snap;
    bit ok;
    for (int n = 0; n < 12; n++) begin
      i = int'($urandom_range(N - 1, 0));
      a = 8'($urandom); b = 8'($urandom); op = 4'($urandom); mode = 4'($urandom);
      txn(i, a, b, op, mode, g, lat, rsp, id, snap, ok);
      checks += 5;
      if (g != i) begin errors++; $display("FAIL rnd_grant[%0d] got %0d exp %0d", n, g, i); end
      if (lat != 2) begin errors++; $display("FAIL rnd_latency[%0d] got %0d exp 2", n, lat); end
      if (rsp !== ref_rsp(a, b, op, mode)) begin errors++; $display("FAIL rnd_rsp[%0d] got %h exp %h", n, rsp, ref_rsp(a, b, op, mode)); end
      if (id != i) begin errors++; $display("FAIL rnd_id[%0d] got %0d exp %0d", n, id, i); end
      if (snap !== {a, b, op, mode} || !ok) begin errors++; $display("FAIL rnd_alu[%0d] got %h idle %0d exp %h idle 1", n, snap, ok, {a, b, op, mode}); end
      model_last = i;
    end
  endtask
  task automatic test_rr_all();
    int grants[$], times[$], ids[$], exp_g[$];
    logic [11:0] exp_q[$], got_q[$];
    int g, e;
    bit took;
    bus.rsp_ready = 1'b1;
    rand_all();
    bus.req_valid = '1;
    #1;
    for (int c = 0; c < 60 && got_q.size() < 8; c++) begin
      took = 1'b0;
      if (bus.rsp_valid) begin got_q.push_back({bus.rsp_data, bus.rsp_flags}); ids.push_back(int'(bus.rsp_id)); end
      if (bus.req_ready != '0 && grants.size() < 8) begin
        g = onehot_idx(bus.req_ready);
        e = g < 0 ? 0 : g;
        grants.push_back(g);
        times.push_back(c);
        exp_q.push_back(ref_rsp(bus.req_a[8*e +: 8], bus.req_b[8*e +: 8], bus.req_op[4*e +: 4], bus.req_mode[4*e +: 4]));
        took = 1'b1;
      end
      step();
      if (took) begin
        rand_all();
        if (grants.size() == 8) bus.req_valid = '0;
      end
    end
    checks++;
    if (grants.size() != 8 || got_q.size() != 8) begin errors++; $display("FAIL rr_count got %0d/%0d exp 8/8", grants.size(), got_q.size()); end
    for (int k = 0; k < grants.size(); k++) begin
      e = rr_pick('1, model_last);
      model_last = e;
      exp_g.push_back(e);
      checks++;
      if (grants[k] != e) begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", k, grants[k], e); end
      if (k > 0) begin
        checks++;
        if (times[k] - times[k-1] != 3) begin errors++; $display("FAIL rr_spacing[%0d] got %0d exp 3", k, times[k] - times[k-1]); end
      end
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks += 2;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rr_rsp[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
      if (ids[k] != exp_g[k]) begin errors++; $display("FAIL rr_id[%0d] got %0d exp %0d", k, ids[k], exp_g[k]); end
    end
  endtask
  task automatic test_backpressure();
    int g, e, other, hid;
    logic [11:0] held, exp;
    bit ok;
    bus.rsp_ready = 1'b0;
    rand_all();
    bus.req_valid = 4'b1010;
    #1;
    e = rr_pick(4'b1010, model_last);
    other = (e == 1) ? 3 : 1;
    exp = ref_rsp(bus.req_a[8*e +: 8], bus.req_b[8*e +: 8], bus.req_op[4*e +: 4], bus.req_mode[4*e +: 4]);
    for (int n = 0; n < 10 && bus.req_ready == '0; n++) step();
    g = onehot_idx(bus.req_ready);
    checks++;
    if (g != e) begin errors++; $display("FAIL bp_grant got %0d exp %0d", g, e); end
    step();
    bus.req_valid = N'(1) << other;
    for (int n = 0; n < 5 && !bus.rsp_valid; n++) step();
    held = {bus.rsp_data, bus.rsp_flags};
    hid = int'(bus.rsp_id);
    checks += 2;
    if (held !== exp) begin errors++; $display("FAIL bp_rsp got %h exp %h", held, exp); end
    if (hid != e) begin errors++; $display("FAIL bp_id got %0d exp %0d", hid, e); end
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (!bus.rsp_valid || {bus.rsp_data, bus.rsp_flags} !== held || int'(bus.rsp_id) != hid || bus.req_ready != '0)
        begin errors++; $display("FAIL bp_hold[%0d] got v%0d %h id%0d rdy %b exp v1 %h id%0d rdy 0", n, bus.rsp_valid, {bus.rsp_data, bus.rsp_flags}, bus.rsp_id, bus.req_ready, held, hid); end
    end
    bus.rsp_ready = 1'b1;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== (N'(1) << other))
      begin errors++; $display("FAIL bp_resume got v%0d rdy %b exp v0 rdy %b", bus.rsp_valid, bus.req_ready, N'(1) << other); end
    model_last = other;
    step();
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain got busy %0d exp 0", busy); end
  endtask
  task automatic test_reset_exec();
    bit seen, ok;
    int e;
    bus.rsp_ready = 1'b1;
    rand_all();
    bus.req_valid = 4'b1000;
    #1;
    for (int n = 0; n < 10 && bus.req_ready == '0; n++) step();
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_exec_busy got %0d exp 1", busy); end
    rst_n = 1'b0;
    bus.req_valid = '0;
    step();
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rst_exec_outputs got %h exp 0", outs); end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 5; n++) begin step(); seen |= bus.rsp_valid; end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_exec_rsp got 1 exp 0"); end
    model_last = N - 1;
    bus.req_valid = '1;
    #1;
    e = rr_pick('1, model_last);
    checks++;
    if (bus.req_ready !== (N'(1) << e)) begin errors++; $display("FAIL rst_exec_first got %b exp %b", bus.req_ready, N'(1) << e); end
    model_last = e;
    step();
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_exec_drain got busy %0d exp 0", busy); end
  endtask
`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock();
    int grants[$];
    int exp_g[3];
    bit ok;
    exp_g = '{1, 1, 2};
    rst_n = 1'b0;
    bus.req_valid = '0;
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    rand_all();
    bus.req_lock = N'(1) << 1;
    bus.req_valid = 4'b0110;
    #1;
    for (int c = 0; c < 30 && grants.size() < 3; c++) begin
      if (bus.req_ready != '0) grants.push_back(onehot_idx(bus.req_ready));
      step();
      if (grants.size() == 1) bus.req_lock = '0;
    end
    drain(ok);
    checks++;
    if (grants.size() != 3 || !ok) begin errors++; $display("FAIL lock_count got %0d exp 3", grants.size()); end
    for (int k = 0; k < grants.size() && k < 3; k++) begin
      checks++;
      if (grants[k] != exp_g[k]) begin errors++; $display("FAIL lock_grant[%0d] got %0d exp %0d", k, grants[k], exp_g[k]); end
    end
  endtask
`endif
  initial begin
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.req_mode = '0;
    bus.rsp_ready = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_rr_all();
    test_backpressure();
    test_reset_exec();
`ifdef ALU_ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
